instr_fetch_unit: RTL and testbench

//  Producer side of the control_unit opcode interface: fetches instructions from

---
 rtl/instr_fetch_unit_pkg.sv | 28 ++
 rtl/instr_fetch_unit_if.sv | 38 +++
 rtl/instr_fetch_unit_pc_next_calc.sv | 35 +++
 rtl/instr_fetch_unit.sv | 96 +++++++++
 tb/tb_instr_fetch_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_pkg
// Description : Shared CPU definitions for the fetch unit: default widths,
//               opcode constants used by control_unit, fetch FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;

  // Opcodes (instr[31:26]) recognised by control_unit
  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_JUMP     = 6'b000010;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] HALT_OP_DEF = 6'b111111;

  // Fetch FSM encoding
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    ISSUE      = 2'd2,
    HALT       = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Bundles the imem handshake, control_unit feedback and the
//               issued-instruction outputs of the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               branch;
  logic               zero;
  logic               jump;
  logic [INSTR_W-1:0] instr;
  logic [5:0]         opCode;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;
  logic               halted;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr, opCode, instr_valid, pc, halted,
    input  imem_ready, imem_rdata, stall, branch, zero, jump
  );

  // Memory / control_unit / datapath side
  modport slave (
    input  imem_req, imem_addr, instr, opCode, instr_valid, pc, halted,
    output imem_ready, imem_rdata, stall, branch, zero, jump
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_pc_next_calc.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_calc
// Description : Combinational next-PC selection. Priority jump > taken branch
//               > sequential; all arithmetic wraps modulo 2^PC_W.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_calc #(
  parameter int PC_W = 32
) (
  input  wire logic [PC_W-1:0] pc,
  input  wire logic [25:0]     target_field,  // instr[25:0]; low half is the branch offset
  input  wire logic            jump,
  input  wire logic            branch,
  input  wire logic            zero,
  output logic      [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] pc1;
  logic [PC_W-1:0] offset;

  assign pc1    = pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign offset = {{(PC_W-16){target_field[15]}}, target_field[15:0]};

  // Select the successor PC; jump keeps the region bits of pc+1
  always_comb begin
    next_pc = pc1;
    if (jump)
      next_pc = {pc1[PC_W-1:26], target_field};
    else if (branch && zero)
      next_pc = pc1 + offset;
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetches instructions from imem, holds the issued instruction
//               for control_unit/datapath and forms the next PC from
//               jump/branch feedback when the instruction retires.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          PC_W     = PC_W_DEF,
  parameter int          INSTR_W  = INSTR_W_DEF,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = HALT_OP_DEF
) (
  input wire logic             clk,
  input wire logic             reset,
  instr_fetch_unit_if.master   bus
);

  fetch_state_t       state;
  fetch_state_t       state_nx;
  logic [PC_W-1:0]    pc_r;
  logic [INSTR_W-1:0] instr_r;
  logic [PC_W-1:0]    next_pc;
  logic               capture;   // imem_ready accepted in FETCH_REQ
  logic               pc_load;   // non-halt retire advances the PC
  logic               is_halt;

  assign is_halt = (instr_r[INSTR_W-1 -: 6] == HALT_OP);

  pc_next_calc #(.PC_W(PC_W)) u_pc_next_calc (
    .pc           (pc_r),
    .target_field (instr_r[25:0]),
    .jump         (bus.jump),
    .branch       (bus.branch),
    .zero         (bus.zero),
    .next_pc      (next_pc)
  );

  // FSM state register; reset abandons any outstanding fetch
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH_IDLE;
    else       state <= state_nx;
  end

  // Next-state and handshake decisions; imem_ready only matters in FETCH_REQ
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    pc_load  = 1'b0;
    case (state)
      FETCH_IDLE: state_nx = FETCH_REQ;
      FETCH_REQ: begin
        if (bus.imem_ready) begin
          capture  = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.stall) begin
          if (is_halt) begin
            state_nx = HALT;
          end else begin
            pc_load  = 1'b1;
            state_nx = FETCH_REQ;
          end
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = FETCH_IDLE;
    endcase
  end

  // PC and instruction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r    <= RESET_PC[PC_W-1:0];
      instr_r <= '0;
    end else begin
      if (capture) instr_r <= bus.imem_rdata;
      if (pc_load) pc_r    <= next_pc;
    end
  end

  assign bus.imem_req    = (state == FETCH_REQ);
  assign bus.imem_addr   = pc_r;
  assign bus.pc          = pc_r;
  assign bus.instr       = instr_r;
  assign bus.opCode      = instr_r[INSTR_W-1 -: 6];
  assign bus.instr_valid = (state == ISSUE);
  assign bus.halted      = (state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A table of fetched
//               words with feedback and expected successor PC drives the DUT;
//               issued instructions are checked against a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic clk;
  logic reset;

  instr_fetch_unit_if #(.PC_W(32), .INSTR_W(32)) bus ();

  instr_fetch_unit #(
    .PC_W     (32),
    .INSTR_W  (32),
    .RESET_PC (32'h0000_0000),
    .HALT_OP  (6'b111111)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          delay;
    int          stalls;
    logic        jump;
    logic        branch;
    logic        zero;
    logic        halt;
    logic [31:0] next_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  localparam int NVEC = 16;

  vec_t        vecs [NVEC];
  exp_t        sb [$];
  logic [31:0] exp_pc;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    exp_t e;
    int   guard;
    v = vecs[k];
    guard = 0;
    while (bus.imem_req !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    chk("req_seen", {31'd0, bus.imem_req}, 32'd1);
    chk("fetch_addr", bus.imem_addr, exp_pc);
    for (int d = 0; d < v.delay; d++) begin
      bus.imem_ready = 1'b0;
      @(negedge clk);
      chk("req_hold", {31'd0, bus.imem_req}, 32'd1);
      chk("addr_hold", bus.imem_addr, exp_pc);
      chk("no_valid_before_ready", {31'd0, bus.instr_valid}, 32'd0);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = v.rdata;
    sb.push_back('{pc: exp_pc, instr: v.rdata});
    @(negedge clk);
    bus.imem_ready = 1'b0;
    bus.imem_rdata = $urandom;
    chk("instr_valid", {31'd0, bus.instr_valid}, 32'd1);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      e = '{pc: 32'd0, instr: 32'd0};
    end else begin
      e = sb.pop_front();
    end
    chk("issue_instr", bus.instr, e.instr);
    chk("issue_pc", bus.pc, e.pc);
    chk("issue_opcode", {26'd0, bus.opCode}, {26'd0, e.instr[31:26]});
    bus.jump   = v.jump;
    bus.branch = v.branch;
    bus.zero   = v.zero;
    for (int s = 0; s < v.stalls; s++) begin
      bus.stall      = 1'b1;
      bus.imem_ready = 1'b1;      // must be ignored outside FETCH_REQ
      bus.imem_rdata = ~v.rdata;
      @(negedge clk);
      chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("stall_instr", bus.instr, e.instr);
      chk("stall_pc", bus.pc, e.pc);
      chk("stall_no_req", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.stall      = 1'b0;
    bus.imem_ready = 1'b0;
    @(negedge clk);
    bus.jump   = 1'b0;
    bus.branch = 1'b0;
    bus.zero   = 1'b0;
    if (v.halt) begin
      chk("halted", {31'd0, bus.halted}, 32'd1);
      chk("halt_pc_kept", bus.pc, e.pc);
    end else begin
      exp_pc = v.next_pc;
      chk("retire_addr", bus.imem_addr, exp_pc);
      chk("retire_req", {31'd0, bus.imem_req}, 32'd1);
    end
  endtask

  // Safety net against a hung DUT handshake
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //            rdata         dly stl jmp br  z  halt next_pc
    vecs[0]  = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0001};
    vecs[1]  = '{32'h1000_FFFD, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[2]  = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[3]  = '{32'h0800_0005, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0005};
    vecs[4]  = '{32'h0000_0020, 3, 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0006};
    vecs[5]  = '{32'h0800_000A, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_000A};
    vecs[6]  = '{32'h1000_FFFC, 1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0007};
    vecs[7]  = '{32'h0800_000A, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_000A};
    vecs[8]  = '{32'h1000_FFFC, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_000B};
    vecs[9]  = '{32'h0BFF_FFFF, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h03FF_FFFF};
    vecs[10] = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0400_0000};
    vecs[11] = '{32'h1000_0004, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0400_0005};
    vecs[12] = '{32'h0800_0010, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0400_0010};
    vecs[13] = '{32'h1000_FFF4, 2, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0400_0005};
    vecs[14] = '{32'h0800_0010, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0400_0010};
    vecs[15] = '{32'hFC00_0000, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0400_0010};

    reset          = 1'b1;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    bus.stall      = 1'b0;
    bus.branch     = 1'b0;
    bus.zero       = 1'b0;
    bus.jump       = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state (imem_ready held high during reset is ignored)
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    chk("rst_pc", bus.pc, 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_opcode", {26'd0, bus.opCode}, 32'd0);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);

    // FETCH_IDLE occupies the first cycle after release
    bus.imem_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("req_after_idle", {31'd0, bus.imem_req}, 32'd1);

    exp_pc = 32'd0;
    for (int k = 0; k < NVEC; k++) run_vec(k);

    // Halted: no further fetching regardless of imem activity
    for (int i = 0; i < 4; i++) begin
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 32'h0000_0020;
      @(negedge clk);
      chk("halt_no_req", {31'd0, bus.imem_req}, 32'd0);
      chk("halt_no_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("halt_sticky", {31'd0, bus.halted}, 32'd1);
    end
    bus.imem_ready = 1'b0;

    // Reset recovers from HALT
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("halt_reset_cleared", {31'd0, bus.halted}, 32'd0);
    @(negedge clk);
    exp_pc = 32'd0;
    run_vec(0);

    // Reset during FETCH_REQ with imem_ready high abandons the fetch
    chk("pre_abort_req", {31'd0, bus.imem_req}, 32'd1);
    chk("pre_abort_pc", bus.pc, 32'd1);
    reset          = 1'b1;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    chk("abort_instr", bus.instr, 32'd0);
    chk("abort_pc", bus.pc, 32'd0);
    chk("abort_req", {31'd0, bus.imem_req}, 32'd0);
    chk("abort_valid", {31'd0, bus.instr_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_req", {31'd0, bus.imem_req}, 32'd1);
    chk("restart_addr", bus.imem_addr, 32'd0);

    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
